count_ctrl: RTL and testbench

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl.sv | 131 +++++++++++++
 tb/tb_count_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_ctrl.sv
// count_ctrl: run/abort sequencer for an external up-counter.
// A prescaler divides clk into ticks. On each tick the managed counter is
// incremented until it equals the latched limit. At that point done pulses and
// the controller either halts (one-shot) or clears and runs again (auto-reload).
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous reset, active low
//   start    - run request (level sampled)
//   stop     - abort request (level sampled, wins over start)
//   oneshot  - 1: halt at limit, 0: auto-reload
//   limit    - terminal count, latched when start is accepted
//   presc    - tick period minus one, latched when start is accepted
//   cnt_val  - current value of the managed counter (fed back)
//   cnt_en   - increment enable to the managed counter
//   cnt_clr  - synchronous clear to the managed counter
//   busy     - high in CLEAR and RUN
//   done     - one-cycle pulse when the limit is reached on a tick
//   state    - FSM state (IDLE=0, CLEAR=1, RUN=2, HALT=3)
//
// state | meaning
// IDLE  | waiting for start, strobes low
// CLEAR | one-cycle clear of the managed counter, prescaler zeroed
// RUN   | prescaler counting, increments on ticks until limit
// HALT  | one-shot finished, waiting for stop or a new start

module count_ctrl #(
    parameter int CNT_W = 5,
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] limit,
    input  logic [DIV_W-1:0] presc,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DIV_W-1:0]   presc_cnt_q;
    logic [DIV_W-1:0]   presc_cnt_d;
    logic [CNT_W-1:0]   limit_l;
    logic [DIV_W-1:0]   presc_l;
    logic               oneshot_l;
    logic               latch_en;
    logic               tick;
    logic               at_limit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            presc_cnt_q <= '0;
            limit_l     <= '0;
            presc_l     <= '0;
            oneshot_l   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_cnt_q <= presc_cnt_d;
            if (latch_en) begin
                limit_l   <= limit;
                presc_l   <= presc;
                oneshot_l <= oneshot;
            end
        end
    end

    // Strobes depend only on registered state, prescaler and cnt_val, so
    // start/stop never reach an output combinationally.
    always_comb begin
        tick     = (state_q == S_RUN) && (presc_cnt_q == presc_l);
        at_limit = (cnt_val == limit_l);
        cnt_en   = tick && !at_limit;
        done     = tick && at_limit;
        cnt_clr  = (state_q == S_CLEAR);
        busy     = (state_q == S_CLEAR) || (state_q == S_RUN);
    end

    always_comb begin
        state_d     = state_q;
        presc_cnt_d = '0;
        latch_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d  = S_CLEAR;
                    latch_en = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                presc_cnt_d = tick ? '0 : presc_cnt_q + DIV_W'(1);
                if (stop) begin
                    state_d = S_IDLE;
                end else if (done) begin
                    // auto-reload keeps the latched settings; only a fresh
                    // accept from IDLE/HALT relatches
                    state_d = oneshot_l ? S_HALT : S_CLEAR;
                end
            end
            S_HALT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d  = S_CLEAR;
                    latch_en = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
module tb_count_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        oneshot;
    logic [4:0]  limit;
    logic [21:0] presc;
    logic [4:0]  cnt_val = '0;
    logic        cnt_en;
    logic        cnt_clr;
    logic        busy;
    logic        done;
    logic [1:0]  state;

    count_ctrl #(.CNT_W(5), .DIV_W(22)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .oneshot (oneshot),
        .limit   (limit),
        .presc   (presc),
        .cnt_val (cnt_val),
        .cnt_en  (cnt_en),
        .cnt_clr (cnt_clr),
        .busy    (busy),
        .done    (done),
        .state   (state)
    );

    always #5 clk = ~clk;

    // managed counter that the controller drives
    always @(posedge clk) begin
        if (cnt_clr)     cnt_val <= '0;
        else if (cnt_en) cnt_val <= cnt_val + 5'd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // output vector order: {cnt_en, cnt_clr, done, busy, state[1:0]}
    localparam logic [5:0] V_IDLE = 6'b0000_00;
    localparam logic [5:0] V_CLR  = 6'b0101_01;
    localparam logic [5:0] V_RUN  = 6'b0001_10;
    localparam logic [5:0] V_EN   = 6'b1001_10;
    localparam logic [5:0] V_DONE = 6'b0011_10;
    localparam logic [5:0] V_HALT = 6'b0000_11;

    typedef struct packed {
        logic [31:0] cyc;
        logic [5:0]  v;
        logic        chk_cv;
        logic [4:0]  cv;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    stim_done = 1'b0;

    task automatic ex(input int c, input logic [5:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.v = v; e.chk_cv = 1'b0; e.cv = '0;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic exv(input int c, input logic [5:0] v, input logic [4:0] cv, input string nm);
        exp_t e;
        e.cyc = c; e.v = v; e.chk_cv = 1'b1; e.cv = cv;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        exp_t       e;
        string      nm;
        logic [5:0] got;
        bit         matched;
        got     = {cnt_en, cnt_clr, done, busy, state};
        matched = 1'b0;
        while (sb_q.size() > 0 && int'(sb_q[0].cyc) <= cyc) begin
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            checks++;
            if (int'(e.cyc) != cyc) begin
                failures++;
                $display("FAIL %s missed: expected at cycle %0d, now %0d", nm, e.cyc, cyc);
            end else begin
                matched = 1'b1;
                if (got !== e.v || (e.chk_cv && cnt_val !== e.cv)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got out=%b cnt_val=%0d expected out=%b cnt_val=%0d",
                             nm, cyc, got, cnt_val, e.v, e.chk_cv ? e.cv : cnt_val);
                end
            end
        end
        if (!matched && (cnt_en === 1'b1 || cnt_clr === 1'b1 || done === 1'b1)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe cyc=%0d got out=%b expected no strobe", cyc, got);
        end
        if (stim_done || cyc > 3000) begin
            checks++;
            if (!stim_done || sb_q.size() != 0) begin
                failures++;
                $display("FAIL end_of_run pending=%0d stim_done=%0d expected pending=0 stim_done=1",
                         sb_q.size(), stim_done);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        int c;
        rst = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
        limit = '0; presc = '0;

        // reset
        repeat (3) tick();
        c = cyc;
        ex(c, V_IDLE, "reset_idle");
        start = 1'b1; limit = 5'd3;
        tick();
        ex(cyc, V_IDLE, "reset_overrides_start");
        rst = 1'b1; start = 1'b0;
        tick();
        ex(cyc, V_IDLE, "idle_after_reset");
        tick();

        // one-shot, presc=0, limit=3; settings changed after accept must not matter
        c = cyc;
        limit = 5'd3; presc = 22'd0; oneshot = 1'b1; start = 1'b1;
        ex(c+1, V_CLR, "a_clr");
        ex(c+2, V_EN, "a_en0");
        ex(c+3, V_EN, "a_en1");
        ex(c+4, V_EN, "a_en2");
        ex(c+5, V_DONE, "a_done");
        exv(c+6, V_HALT, 5'd3, "a_halt");
        ex(c+7, V_HALT, "a_halt_hold");
        tick();
        start = 1'b0; limit = 5'd1; presc = 22'd5;
        repeat (7) tick();
        start = 1'b1; stop = 1'b1;
        ex(c+9, V_IDLE, "a_halt_startstop");
        ex(c+10, V_IDLE, "a_idle_hold");
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (2) tick();

        // start+stop together in IDLE
        c = cyc;
        start = 1'b1; stop = 1'b1;
        ex(c+1, V_IDLE, "idle_startstop");
        tick();
        start = 1'b0; stop = 1'b0;
        tick();

        // auto-reload, presc=2, limit=2
        c = cyc;
        presc = 22'd2; limit = 5'd2; oneshot = 1'b0; start = 1'b1;
        ex(c+1, V_CLR, "b_clr0");
        ex(c+4, V_EN, "b_en0");
        ex(c+5, V_RUN, "b_run_gap");
        ex(c+7, V_EN, "b_en1");
        exv(c+10, V_DONE, 5'd2, "b_done0");
        ex(c+11, V_CLR, "b_clr1");
        ex(c+14, V_EN, "b_en2");
        ex(c+17, V_EN, "b_en3");
        ex(c+20, V_DONE, "b_done1");
        ex(c+21, V_CLR, "b_clr2");
        ex(c+24, V_EN, "b_en4");
        exv(c+26, V_IDLE, 5'd1, "b_stopped");
        tick();
        start = 1'b0;
        repeat (4) tick();
        presc = 22'd0; limit = 5'd7;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) tick();

        // limit=0: done on first tick, no increment; then relatch from HALT
        c = cyc;
        presc = 22'd4; limit = 5'd0; oneshot = 1'b1; start = 1'b1;
        ex(c+1, V_CLR, "c_clr");
        ex(c+3, V_RUN, "c_run");
        exv(c+6, V_DONE, 5'd0, "c_done_lim0");
        exv(c+7, V_HALT, 5'd0, "c_halt");
        tick();
        start = 1'b0;
        repeat (7) tick();
        start = 1'b1; limit = 5'd1; presc = 22'd0;
        ex(c+9, V_CLR, "c_relatch_clr");
        ex(c+10, V_EN, "c_relatch_en");
        ex(c+11, V_DONE, "c_relatch_done");
        exv(c+12, V_HALT, 5'd1, "c_relatch_halt");
        tick();
        start = 1'b0;
        repeat (3) tick();
        stop = 1'b1;
        ex(c+13, V_IDLE, "c_halt_stop");
        tick();
        stop = 1'b0;
        tick();

        // stop in the tick cycle with cnt_val=1, limit=5
        c = cyc;
        presc = 22'd1; limit = 5'd5; oneshot = 1'b1; start = 1'b1;
        ex(c+1, V_CLR, "d_clr");
        ex(c+2, V_RUN, "d_run");
        exv(c+3, V_EN, 5'd0, "d_en0");
        ex(c+4, V_RUN, "d_run2");
        exv(c+5, V_EN, 5'd1, "d_en_stop");
        exv(c+6, V_IDLE, 5'd2, "d_idle");
        exv(c+8, V_IDLE, 5'd2, "d_cnt_hold");
        tick();
        start = 1'b0;
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();

        // reset in RUN just before a scheduled increment
        c = cyc;
        presc = 22'd2; limit = 5'd5; oneshot = 1'b0; start = 1'b1;
        ex(c+1, V_CLR, "e_clr");
        exv(c+4, V_EN, 5'd0, "e_en0");
        ex(c+6, V_RUN, "e_run");
        exv(c+7, V_IDLE, 5'd1, "e_reset_abort");
        ex(c+8, V_IDLE, "e_reset_hold");
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // restart after reset
        c = cyc;
        presc = 22'd0; limit = 5'd1; oneshot = 1'b1; start = 1'b1;
        ex(c+1, V_CLR, "f_clr");
        ex(c+2, V_EN, "f_en");
        ex(c+3, V_DONE, "f_done");
        ex(c+4, V_HALT, "f_halt");
        tick();
        start = 1'b0;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) tick();

        stim_done = 1'b1;
    end

endmodule
